// File: rtl/norm_check_ctrl_pkg.sv
// Dilithium constants shared by the norm-check sequencer: modulus, per-level
// gamma/beta/K/L, mode codes and the bound/poly-count helpers.
package norm_check_ctrl_pkg;

    localparam int unsigned Q       = 8380417;
    localparam int unsigned N_COEFF = 256;

    localparam logic [1:0] MODE_G2_SUB_BETA = 2'd0;
    localparam logic [1:0] MODE_G1_SUB_BETA = 2'd1;
    localparam logic [1:0] MODE_G2          = 2'd2;

    localparam logic [23:0] GAMMA1_L2  = 24'd131072;
    localparam logic [23:0] GAMMA1_L35 = 24'd524288;
    localparam logic [23:0] GAMMA2_L2  = 24'd95232;
    localparam logic [23:0] GAMMA2_L35 = 24'd261888;
    localparam logic [23:0] BETA_L2    = 24'd78;
    localparam logic [23:0] BETA_L3    = 24'd196;
    localparam logic [23:0] BETA_L5    = 24'd120;

    localparam logic [3:0] K_L2 = 4'd4, K_L3 = 4'd6, K_L5 = 4'd8;
    localparam logic [3:0] L_L2 = 4'd4, L_L3 = 4'd5, L_L5 = 4'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_e;

    // Unknown security levels fall back to level 5.
    function automatic logic [3:0] polys_for(input logic [2:0] sec_lvl, input logic [1:0] mode);
        logic [3:0] k;
        logic [3:0] l;
        case (sec_lvl)
            3'd2:    begin k = K_L2; l = L_L2; end
            3'd3:    begin k = K_L3; l = L_L3; end
            default: begin k = K_L5; l = L_L5; end
        endcase
        return (mode == MODE_G1_SUB_BETA) ? l : k;
    endfunction

    function automatic logic [23:0] bound_for(input logic [2:0] sec_lvl, input logic [1:0] mode);
        logic [23:0] g1;
        logic [23:0] g2;
        logic [23:0] b;
        case (sec_lvl)
            3'd2:    begin g1 = GAMMA1_L2;  g2 = GAMMA2_L2;  b = BETA_L2; end
            3'd3:    begin g1 = GAMMA1_L35; g2 = GAMMA2_L35; b = BETA_L3; end
            default: begin g1 = GAMMA1_L35; g2 = GAMMA2_L35; b = BETA_L5; end
        endcase
        case (mode)
            MODE_G2_SUB_BETA: return g2 - b;
            MODE_G1_SUB_BETA: return g1 - b;
            default:          return g2;
        endcase
    endfunction

endpackage

// File: rtl/norm_check_ctrl_norm_check.sv
// Combinational infinity-norm bound compare over one stream word: rejects when
// any centered lane magnitude reaches the bound selected by level and mode.
module norm_check
    import norm_check_ctrl_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CW    = 24
) (
    input  logic                validi,
    input  logic [LANES*CW-1:0] di,
    input  logic [2:0]          sec_lvl,
    input  logic [1:0]          mode,
    output logic                rej
);

    localparam logic [CW-1:0] QW   = CW'(Q);
    localparam logic [CW-1:0] HALF = CW'((Q - 1) / 2);

    logic [CW-1:0]    bound;
    logic [LANES-1:0] over;

    assign bound = CW'(bound_for(sec_lvl, mode));

    // Values above (q-1)/2 represent negatives; out-of-range inputs always reject.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CW-1:0] c;
        logic [CW-1:0] mag;
        assign c       = di[i*CW +: CW];
        assign mag     = (c > HALF) ? QW - c : c;
        assign over[i] = (c >= QW) || (mag >= bound);
    end

    assign rej = validi && (|over);

endmodule

// File: rtl/norm_check_ctrl.sv
// Sequences one norm-bound check over a full polynomial vector: counts words and
// polys, folds per-word rejects into a sticky flag and reports done/rej.
module norm_check_ctrl
    import norm_check_ctrl_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int CW         = 24,
    parameter int N          = N_COEFF,
    parameter int EARLY_EXIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          sec_lvl,
    input  logic [1:0]          mode,
    input  logic                validi,
    input  logic [LANES*CW-1:0] di,
    output logic                readyo,
    output logic                busy,
    output logic                done,
    output logic                rej
);

    localparam logic [5:0] LAST_WORD = 6'(N / LANES - 1);

    state_e     state;
    logic [5:0] word_cnt;
    logic [2:0] poly_cnt;
    logic [2:0] last_poly;
    logic [2:0] lvl_q;
    logic [1:0] mode_q;
    logic       hit_q;
    logic       sticky;
    logic       xfer;
    logic       nc_rej;
    logic       exit_now;

    assign xfer = validi && readyo;

    norm_check #(.LANES(LANES), .CW(CW)) u_norm (
        .validi  (xfer),
        .di      (di),
        .sec_lvl (lvl_q),
        .mode    (mode_q),
        .rej     (nc_rej)
    );

    assign exit_now = xfer && (((word_cnt == LAST_WORD) && (poly_cnt == last_poly))
                               || ((EARLY_EXIT != 0) && nc_rej));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            readyo    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rej       <= 1'b0;
            word_cnt  <= '0;
            poly_cnt  <= '0;
            last_poly <= '0;
            lvl_q     <= '0;
            mode_q    <= '0;
            hit_q     <= 1'b0;
            sticky    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    lvl_q     <= sec_lvl;
                    mode_q    <= mode;
                    last_poly <= 3'(polys_for(sec_lvl, mode) - 4'd1);
                    word_cnt  <= '0;
                    poly_cnt  <= '0;
                    hit_q     <= 1'b0;
                    sticky    <= 1'b0;
                    rej       <= 1'b0;
                    busy      <= 1'b1;
                    readyo    <= 1'b1;
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    hit_q  <= nc_rej;
                    sticky <= sticky | hit_q;
                    if (xfer) begin
                        word_cnt <= word_cnt + 6'd1;
                        if (word_cnt == LAST_WORD) poly_cnt <= poly_cnt + 3'd1;
                    end
                    if (exit_now) begin
                        readyo <= 1'b0;
                        state  <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // The final word's hit is still in hit_q here.
                    sticky <= sticky | hit_q;
                    rej    <= sticky | hit_q;
                    hit_q  <= 1'b0;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
